sti_frame_sched: RTL and testbench

Round-robin scheduler that shares one parallel-to-serial/DAC datapath (load/pi_* command port, so_valid/so_data serial output, pixel_finish) among N_REQ frame producers. It grants one requester per frame, drives the one-cycle load strobe with that requester's command, and tracks the serialized bit count on so_valid to detect frame completion. It asserts pi_end on the globally last frame, then waits for pixel_finish before reporting completion. It sits between the frame producers and the serializer instance in the top level.

---
 rtl/sti_pkg.sv | 41 ++++
 rtl/sti_frame_sched_rr_arbiter.sv | 34 +++
 rtl/sti_frame_sched.sv | 189 ++++++++++++++++++
 tb/tb_sti_frame_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sti_pkg.sv
// Shared definitions for the frame scheduler.
//   - sched_state_e : scheduler FSM states
//   - LEN8..LEN32   : frame length codes carried in cfg[4:3]
//   - CFG_*         : bit offsets inside a requester's 5-bit cfg slice
//   - bits_for_len  : serialized bit count for a length code
package sti_pkg;

    localparam int DATA_W   = 16;
    localparam int CFG_W    = 5;
    localparam int CFG_LOW  = 0;
    localparam int CFG_MSB  = 1;
    localparam int CFG_FILL = 2;
    localparam int CFG_LEN  = 3;

    localparam logic [1:0] LEN8  = 2'd0;
    localparam logic [1:0] LEN16 = 2'd1;
    localparam logic [1:0] LEN24 = 2'd2;
    localparam logic [1:0] LEN32 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_START,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } sched_state_e;

    function automatic logic [5:0] bits_for_len(input logic [1:0] len);
        logic [5:0] bits;
        bits = 6'd8;
        case (len)
            LEN8:  bits = 6'd8;
            LEN16: bits = 6'd16;
            LEN24: bits = 6'd24;
            LEN32: bits = 6'd32;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/sti_frame_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after
// ptr_i, wrapping around. Purely combinational.
//   req_i   : request vector
//   ptr_i   : highest-priority index this cycle
//   gnt_o   : one-hot grant
//   idx_o   : index of the granted request
//   valid_o : some request was granted
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        int idx;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!valid_o && req_i[idx]) begin
                valid_o    = 1'b1;
                gnt_o[idx] = 1'b1;
                idx_o      = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/sti_frame_sched.sv
// Round-robin frame scheduler in front of a shared serializer/DAC path.
// Grants one requester per frame, issues a one-cycle load with the latched
// command, counts serialized bits on so_valid, and on the stream's final
// frame waits for pixel_finish before signalling completion.
//   req_valid/req_last/req_data/req_cfg : requester side, req_ready = accept
//   load, pi_*                          : command port to the serializer
//   so_valid, pixel_finish              : serializer progress
//   busy, sched_done, err               : status (done/err sticky)
//
// state         | meaning
// ST_IDLE       | pick next eligible requester, latch its command
// ST_LOAD       | one-cycle load strobe, arm counters
// ST_WAIT_START | wait for first so_valid, timeout -> err
// ST_SHIFT      | count so_valid bits until frame length reached
// ST_DRAIN      | last frame sent, wait for pixel_finish
// ST_DONE       | stream complete, terminal until reset
module sti_frame_sched
    import sti_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TMO   = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [DATA_W*N_REQ-1:0] req_data,
    input  logic [CFG_W*N_REQ-1:0]  req_cfg,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    load,
    output logic [DATA_W-1:0]       pi_data,
    output logic [1:0]              pi_length,
    output logic                    pi_fill,
    output logic                    pi_msb,
    output logic                    pi_low,
    output logic                    pi_end,
    input  logic                    so_valid,
    input  logic                    pixel_finish,
    output logic                    busy,
    output logic                    sched_done,
    output logic                    err
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TMO + 1);

    sched_state_e      state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]  retired_q, retired_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        len_q, len_d;
    logic              fill_q, fill_d;
    logic              msb_q, msb_d;
    logic              low_q, low_d;
    logic              end_q, end_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              err_q, err_d;

    logic [N_REQ-1:0]  arb_gnt;
    logic [PW-1:0]     arb_idx;
    logic              arb_valid;
    logic [CFG_W-1:0]  cfg_sel;
    logic [N_REQ-1:0]  retired_next;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i   (req_valid & ~retired_q),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign cfg_sel      = req_cfg[CFG_W*arb_idx +: CFG_W];
    assign retired_next = retired_q | (req_last & arb_gnt);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        retired_d = retired_q;
        data_d    = data_q;
        len_d     = len_q;
        fill_d    = fill_q;
        msb_d     = msb_q;
        low_d     = low_q;
        end_d     = end_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        req_ready = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    // Held off during reset so outputs read zero while it is asserted.
                    req_ready = arb_gnt & {N_REQ{~reset}};
                    data_d    = req_data[DATA_W*arb_idx +: DATA_W];
                    len_d     = cfg_sel[CFG_LEN +: 2];
                    fill_d    = cfg_sel[CFG_FILL];
                    msb_d     = cfg_sel[CFG_MSB];
                    low_d     = cfg_sel[CFG_LOW];
                    retired_d = retired_next;
                    end_d     = &retired_next;
                    rr_ptr_d  = (arb_idx == PW'(N_REQ - 1)) ? '0 : arb_idx + PW'(1);
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bit_cnt_d = '0;
                tmo_d     = TW'(TMO);
                state_d   = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (so_valid) begin
                    bit_cnt_d = 6'd1;
                    state_d   = ST_SHIFT;
                end else if (tmo_q <= TW'(1)) begin
                    // Frame is dropped; retire state and pointer already advanced.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            ST_SHIFT: begin
                if (so_valid) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_d == bits_for_len(len_q)) begin
                        state_d = end_q ? ST_DRAIN : ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (pixel_finish) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            retired_q <= '0;
            data_q    <= '0;
            len_q     <= '0;
            fill_q    <= 1'b0;
            msb_q     <= 1'b0;
            low_q     <= 1'b0;
            end_q     <= 1'b0;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            retired_q <= retired_d;
            data_q    <= data_d;
            len_q     <= len_d;
            fill_q    <= fill_d;
            msb_q     <= msb_d;
            low_q     <= low_d;
            end_q     <= end_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    assign load       = (state_q == ST_LOAD);
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_WAIT_START) ||
                        (state_q == ST_SHIFT) || (state_q == ST_DRAIN);
    assign sched_done = (state_q == ST_DONE);
    assign err        = err_q;
    assign pi_data    = data_q;
    assign pi_length  = len_q;
    assign pi_fill    = fill_q;
    assign pi_msb     = msb_q;
    assign pi_low     = low_q;
    assign pi_end     = end_q;

endmodule

// File: tb/tb_sti_frame_sched.sv
module tb_sti_frame_sched;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [16*N-1:0] req_data;
    logic [5*N-1:0]  req_cfg;
    logic            load, pi_fill, pi_msb, pi_low, pi_end;
    logic [15:0]     pi_data;
    logic [1:0]      pi_length;
    logic            so_valid, pixel_finish, busy, sched_done, err;

    sti_frame_sched #(.N_REQ(N), .TMO(15)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_cfg(req_cfg), .req_ready(req_ready), .load(load),
        .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
        .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .so_valid(so_valid), .pixel_finish(pixel_finish), .busy(busy),
        .sched_done(sched_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic [1:0]  len;
        logic [2:0]  opts;   // {fill, msb, low}
        logic        pend;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [N-1:0] s_ready;
    logic        s_load;
    logic        prev_ready = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    // Scoreboard: grant and load compared against the expected frame order.
    always @(negedge clk) begin
        if (req_ready != '0) begin
            if (exp_q.size() == 0) check_val("ready_unexpected", 32'(req_ready), 32'd0);
            else check_val("grant_idx", 32'(req_ready), 32'(1 << exp_q[0].idx));
        end
        if (load) begin
            check_val("load_after_ready", 32'(prev_ready), 32'd1);
            if (exp_q.size() == 0) begin
                check_val("load_unexpected", 32'(load), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("pi_data", 32'(pi_data), 32'(e.data));
                check_val("pi_length", 32'(pi_length), 32'(e.len));
                check_val("pi_opts", 32'({pi_fill, pi_msb, pi_low}), 32'(e.opts));
                check_val("pi_end", 32'(pi_end), 32'(e.pend));
            end
        end
        prev_ready = (req_ready != '0);
    end

    task automatic cycle();
        @(negedge clk);
        s_ready = req_ready;
        s_load  = load;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (s_ready[i]) req_valid[i] = 1'b0;
    endtask

    task automatic present(input int i, input logic [15:0] d, input logic [1:0] len,
                           input logic [2:0] opts, input logic last, input logic pend);
        exp_t e;
        req_valid[i]        = 1'b1;
        req_last[i]         = last;
        req_data[16*i +: 16] = d;
        req_cfg[5*i +: 5]   = {len, opts};
        e.idx = i; e.data = d; e.len = len; e.opts = opts; e.pend = pend;
        exp_q.push_back(e);
    endtask

    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (s_load) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("load_timeout", 32'(s_load), 32'd1);
    endtask

    // Feeds nbits so_valid cycles, optionally pausing for gap_len cycles after gap_at bits.
    task automatic run_frame(input int nbits, input int gap_at, input int gap_len, input logic is_end);
        bit ok;
        wait_load(ok);
        if (!ok) return;
        so_valid = 1'b1;
        for (int b = 0; b < nbits; b++) begin
            if (gap_len > 0 && b == gap_at) begin
                so_valid = 1'b0;
                repeat (gap_len) cycle();
                check_val("busy_in_gap", 32'(busy), 32'd1);
                so_valid = 1'b1;
            end
            if (b == nbits - 1) check_val("busy_pre_last", 32'(busy), 32'd1);
            cycle();
        end
        so_valid = 1'b0;
        check_val("busy_after_frame", 32'(busy), 32'(is_end));
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_ready"}, 32'(req_ready), 32'd0);
        check_val({tag, "_ctl"}, 32'({load, busy, sched_done, err, pi_end}), 32'd0);
        check_val({tag, "_cmd"}, 32'({pi_data, pi_length, pi_fill, pi_msb, pi_low}), 32'd0);
    endtask

    initial begin
        bit ok;
        reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; req_cfg = '0;
        so_valid = 1'b0; pixel_finish = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check_quiet("reset");
        reset = 1'b0;

        // Retire 1..3, then req0 is the stream's final frame.
        present(1, 16'h1111, 2'd0, 3'b000, 1'b1, 1'b0);
        present(2, 16'h2222, 2'd0, 3'b100, 1'b1, 1'b0);
        present(3, 16'h3333, 2'd0, 3'b001, 1'b1, 1'b0);
        pixel_finish = 1'b1;
        run_frame(8, 0, 0, 1'b0);
        pixel_finish = 1'b0;
        check_val("done_early", 32'(sched_done), 32'd0);
        run_frame(8, 0, 0, 1'b0);
        run_frame(8, 0, 0, 1'b0);
        present(0, 16'hA5C3, 2'd1, 3'b010, 1'b1, 1'b1);
        run_frame(16, 0, 0, 1'b1);
        repeat (2) cycle();
        check_val("drain_hold", 32'({busy, sched_done}), 32'b10);
        pixel_finish = 1'b1;
        cycle();
        pixel_finish = 1'b0;
        check_val("done_set", 32'({busy, sched_done}), 32'b01);
        req_valid[2] = 1'b1;
        repeat (2) cycle();
        req_valid[2] = 1'b0;
        check_val("done_sticky", 32'(sched_done), 32'd1);

        // Round robin across all four, then req0 again.
        reset = 1'b1; cycle(); reset = 1'b0;
        for (int i = 0; i < N; i++) present(i, 16'(16'h0100 * (i + 1) + i), 2'd0, 3'(i), 1'b0, 1'b0);
        run_frame(8, 0, 0, 1'b0);
        present(0, 16'hBEEF, 2'd0, 3'b111, 1'b0, 1'b0);
        repeat (4) run_frame(8, 0, 0, 1'b0);
        present(1, 16'h0ABC, 2'd0, 3'b000, 1'b0, 1'b0);
        run_frame(8, 0, 0, 1'b0);

        // rr_ptr is now 2: req3 wins over req1.
        present(3, 16'h3003, 2'd0, 3'b000, 1'b0, 1'b0);
        present(1, 16'h1001, 2'd0, 3'b000, 1'b0, 1'b0);
        run_frame(8, 0, 0, 1'b0);
        run_frame(8, 0, 0, 1'b0);

        // 24 then 32 bits, the second with a 3-cycle hole.
        present(2, 16'h2424, 2'd2, 3'b101, 1'b0, 1'b0);
        present(3, 16'h3232, 2'd3, 3'b011, 1'b0, 1'b0);
        run_frame(24, 0, 0, 1'b0);
        run_frame(32, 12, 3, 1'b0);

        // Start timeout on req0, req1 still served afterwards.
        present(0, 16'h0DEA, 2'd0, 3'b000, 1'b0, 1'b0);
        present(1, 16'h1EAD, 2'd0, 3'b000, 1'b1, 1'b0);
        wait_load(ok);
        repeat (14) cycle();
        check_val("tmo_pre", 32'({err, busy}), 32'b01);
        cycle();
        check_val("tmo_hit", 32'({err, busy}), 32'b10);
        run_frame(8, 0, 0, 1'b0);
        check_val("err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a frame at bit 10.
        present(2, 16'hCAFE, 2'd1, 3'b111, 1'b0, 1'b0);
        wait_load(ok);
        so_valid = 1'b1;
        repeat (10) cycle();
        check_val("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1; so_valid = 1'b0;
        cycle();
        check_quiet("midreset");
        reset = 1'b0;
        // req1 was retired and rr_ptr was 3 before reset.
        present(1, 16'h5151, 2'd0, 3'b000, 1'b0, 1'b0);
        present(3, 16'h5353, 2'd0, 3'b000, 1'b0, 1'b0);
        run_frame(8, 0, 0, 1'b0);
        run_frame(8, 0, 0, 1'b0);
        cycle();

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
